bcd_counter_ndigit: RTL and testbench

Parametrised multi-digit BCD counter, the successor to our single-digit 0–9 counter. It counts up or down across `NUM_DIGITS` cascaded decimal digits and supports synchronous clear, parallel load with BCD validation, and wrap or saturate mode. It also provides a cascade terminal-count output and a sticky overflow flag. It feeds display and timing logic wherever a decimal count wider than one digit is needed.

---
 rtl/bcd_counter_ndigit_pkg.sv | 13 +
 rtl/bcd_counter_ndigit_digit.sv | 39 +++
 rtl/bcd_counter_ndigit.sv | 108 ++++++++++
 tb/tb_bcd_counter_ndigit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_ndigit_pkg.sv
// Shared types, digit limits and the BCD validity check for the multi-digit BCD counter.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_counter_ndigit_digit.sv
// One decimal digit of the counter chain: computes the stepped digit value and the
// carry/borrow passed to the next more-significant digit.
module bcd_digit_cell
  import bcd_counter_pkg::*;
(
  input  logic       step,
  input  logic       up_dn,
  input  logic       cin,
  input  bcd_digit_t d,
  output bcd_digit_t nxt,
  output logic       cout
);

  logic at_term_s;

  // Next digit value and carry/borrow-out for this position.
  always_comb begin
    at_term_s = 1'b0;
    nxt       = d;
    if (up_dn) begin
      at_term_s = (d == BCD_MAX);
    end else begin
      at_term_s = (d == BCD_MIN);
    end
    cout = cin & at_term_s;
    if (step && cin) begin
      if (at_term_s) begin
        nxt = up_dn ? BCD_MIN : BCD_MAX;
      end else if (up_dn) begin
        nxt = d + 4'd1;
      end else begin
        nxt = d - 4'd1;
      end
    end else begin
      nxt = d;
    end
  end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit up/down BCD counter with clear, validated parallel load, wrap or saturate
// at the terminal value, cascade terminal count and sticky overflow.
module bcd_counter_ndigit
  import bcd_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 32'd2,
  parameter bit          WRAP_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clr,
  input  logic                    ld,
  input  logic [4*NUM_DIGITS-1:0] ld_val,
  output logic [4*NUM_DIGITS-1:0] cnt,
  output logic                    vld,
  output logic                    tc,
  output logic                    ovf,
  output logic                    ld_err
);

  localparam int unsigned W = 4 * NUM_DIGITS;

  logic [W-1:0]          cnt_r, cnt_nxt_s, step_val_s;
  logic                  vld_r, vld_nxt_s;
  logic                  ovf_r, ovf_nxt_s;
  logic                  ld_err_r, ld_err_nxt_s;
  logic [NUM_DIGITS:0]   carry_s;
  logic [NUM_DIGITS-1:0] nib_ok_s;
  logic                  ld_ok_s;
  logic                  term_s;

  // carry_s[i] is high when every digit below i sits at the terminal digit value.
  assign carry_s[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .step  (en),
      .up_dn (up_dn),
      .cin   (carry_s[i]),
      .d     (cnt_r[4*i +: 4]),
      .nxt   (step_val_s[4*i +: 4]),
      .cout  (carry_s[i+1])
    );
    assign nib_ok_s[i] = is_bcd(ld_val[4*i +: 4]);
  end

  assign ld_ok_s = &nib_ok_s;
  assign term_s  = carry_s[NUM_DIGITS];
  assign tc      = en & term_s;

  // Priority mux: clr over ld over en; the stepped chain value wraps on its own.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    vld_nxt_s    = 1'b0;
    ovf_nxt_s    = ovf_r;
    ld_err_nxt_s = 1'b0;
    if (clr) begin
      cnt_nxt_s = '0;
      ovf_nxt_s = 1'b0;
      vld_nxt_s = 1'b1;
    end else if (ld) begin
      if (ld_ok_s) begin
        cnt_nxt_s = ld_val;
        vld_nxt_s = 1'b1;
      end else begin
        ld_err_nxt_s = 1'b1;
      end
    end else if (en) begin
      if (term_s) begin
        ovf_nxt_s = 1'b1;
        if (WRAP_EN) begin
          cnt_nxt_s = step_val_s;
          vld_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end else begin
        cnt_nxt_s = step_val_s;
        vld_nxt_s = 1'b1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      vld_r    <= 1'b0;
      ovf_r    <= 1'b0;
      ld_err_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      vld_r    <= vld_nxt_s;
      ovf_r    <= ovf_nxt_s;
      ld_err_r <= ld_err_nxt_s;
    end
  end

  assign cnt    = cnt_r;
  assign vld    = vld_r;
  assign ovf    = ovf_r;
  assign ld_err = ld_err_r;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench: an integer-valued reference model predicts both a wrapping and a
// saturating 2-digit counter; a monitor compares registered outputs one edge later.
module tb_bcd_counter_ndigit;

  localparam int N    = 2;
  localparam int W    = 4 * N;
  localparam int MAXV = 10 ** N - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1, en = 1'b0, up_dn = 1'b1, clr = 1'b0, ld = 1'b0;
  logic [W-1:0] ld_val = '0;
  logic [W-1:0] cnt_w, cnt_s;
  logic         vld_w, tc_w, ovf_w, err_w;
  logic         vld_s, tc_s, ovf_s, err_s;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.NUM_DIGITS(N), .WRAP_EN(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .ld(ld), .ld_val(ld_val),
    .cnt(cnt_w), .vld(vld_w), .tc(tc_w), .ovf(ovf_w), .ld_err(err_w));

  bcd_counter_ndigit #(.NUM_DIGITS(N), .WRAP_EN(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .ld(ld), .ld_val(ld_val),
    .cnt(cnt_s), .vld(vld_s), .tc(tc_s), .ovf(ovf_s), .ld_err(err_s));

  typedef struct {
    logic [W-1:0] cw; bit vw; bit ow; bit ew;
    logic [W-1:0] cs; bit vs; bit os; bit es;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   tests = 0;
  int   fails = 0;

  // Reference model: counter values held as plain integers.
  int mw_v = 0, ms_v = 0;
  bit mw_o = 1'b0, ms_o = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int x;
    x = v;
    for (int i = 0; i < N; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  task automatic from_bcd(input logic [W-1:0] b, output int v, output bit ok);
    int mul;
    int nib;
    v = 0; mul = 1; ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      nib = int'(b[4*i +: 4]);
      if (nib > 9) ok = 1'b0;
      v = v + nib * mul;
      mul = mul * 10;
    end
  endtask

  task automatic mstep(input bit wrap, input bit r, input bit c, input bit l, input bit ok,
                       input int ldv, input bit e, input bit u,
                       inout int v, inout bit o, output bit vl);
    int term;
    vl = 1'b0;
    term = u ? MAXV : 0;
    if (r) begin
      v = 0; o = 1'b0;
    end else if (c) begin
      v = 0; o = 1'b0; vl = 1'b1;
    end else if (l) begin
      if (ok) begin v = ldv; vl = 1'b1; end
    end else if (e) begin
      if (v == term) begin
        o = 1'b1;
        if (wrap) begin v = u ? 0 : MAXV; vl = 1'b1; end
      end else begin
        v = u ? v + 1 : v - 1;
        vl = 1'b1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit l, input logic [W-1:0] lv,
                       input bit e, input bit u);
    int   ldv;
    bit   ok, vw, vs;
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; clr = c; ld = l; ld_val = lv; en = e; up_dn = u;
    #1;
    chk("tc_wrap", tc_w, e && (u ? (mw_v == MAXV) : (mw_v == 0)));
    chk("tc_sat",  tc_s, e && (u ? (ms_v == MAXV) : (ms_v == 0)));
    from_bcd(lv, ldv, ok);
    mstep(1'b1, r, c, l, ok, ldv, e, u, mw_v, mw_o, vw);
    mstep(1'b0, r, c, l, ok, ldv, e, u, ms_v, ms_o, vs);
    x.cw = to_bcd(mw_v); x.vw = vw; x.ow = mw_o;
    x.cs = to_bcd(ms_v); x.vs = vs; x.os = ms_o;
    x.ew = !r && !c && l && !ok;
    x.es = x.ew;
    q.push_back(x);
  endtask

  // Monitor: every edge with a pending expectation is compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_x = q.pop_front();
        chk("cnt_wrap", cnt_w, mon_x.cw);
        chk("vld_wrap", vld_w, mon_x.vw);
        chk("ovf_wrap", ovf_w, mon_x.ow);
        chk("lderr_wrap", err_w, mon_x.ew);
        chk("cnt_sat", cnt_s, mon_x.cs);
        chk("vld_sat", vld_s, mon_x.vs);
        chk("ovf_sat", ovf_s, mon_x.os);
        chk("lderr_sat", err_s, mon_x.es);
      end
    end
  end

  initial begin
    logic [W-1:0] lv;
    bit r, c, l, e, u;
    // Reset, then count up through the 09->10 carry.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // Load 98 and count up across the wrap.
    cycle(1'b0, 1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // Load 01 and count down into the bottom terminal value.
    cycle(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    // Rejected load, then an idle cycle to see the pulse end.
    cycle(1'b0, 1'b0, 1'b1, 8'h3A, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    // Clear beats load and enable at 45.
    cycle(1'b0, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1);
    // Reset mid-count at 37 with enable held, then resume.
    cycle(1'b0, 1'b0, 1'b1, 8'h37, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      l = ($urandom_range(0, 99) < 10);
      e = ($urandom_range(0, 99) < 75);
      u = ($urandom_range(0, 99) < 55);
      lv = W'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < N; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      cycle(r, c, l, lv, e, u);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
